pll_reset_sequencer: RTL and testbench

Controls the system PLL (74.25 MHz reference in, video and SDRAM/core clocks out). It holds the PLL in reset for a defined interval and waits for a stable lock, retrying on timeout. It then releases the downstream clock-domain resets one at a time, in a fixed order. It runs on the PLL reference clock and is the only block that drives the PLL reset and the per-domain reset requests. It watches for loss of lock and restarts the whole sequence when lock drops.

---
 rtl/pll_reset_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for stable lock with
// timeout/retry, then releases downstream domain resets one at a time.
module pll_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned RELEASE_GAP         = 8,
    parameter int unsigned NUM_DOMAINS         = 3
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [3:0]             retry_count,
    output logic                   timeout_err
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TOUT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(RELEASE_GAP + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic lock_meta_q;
    logic lock_s_q;

    logic [HOLD_W-1:0]      hold_cnt_q,    hold_cnt_d;
    logic [STAB_W-1:0]      stable_cnt_q,  stable_cnt_d;
    logic [TOUT_W-1:0]      timeout_cnt_q, timeout_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q,     gap_cnt_d;

    logic                   pll_rst_q,      pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
    logic                   ready_q,        ready_d;
    logic                   lock_lost_q,    lock_lost_d;
    logic [3:0]             retry_count_q,  retry_count_d;
    logic                   timeout_err_q,  timeout_err_d;

    logic                   restart;

    // pll_locked is asynchronous to refclk; only lock_s_q is used for decisions.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        stable_cnt_d   = stable_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        pll_rst_d      = pll_rst_q;
        domain_reset_d = domain_reset_q;
        ready_d        = ready_q;
        lock_lost_d    = 1'b0;
        retry_count_d  = retry_count_q;
        timeout_err_d  = timeout_err_q;
        restart        = 1'b0;

        case (state_q)
            S_RESET: begin
                pll_rst_d      = 1'b1;
                domain_reset_d = '1;
                ready_d        = 1'b0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                timeout_cnt_d = timeout_cnt_q + 1'b1;
                stable_cnt_d  = lock_s_q ? stable_cnt_q + 1'b1 : '0;
                // Stable lock takes priority over a timeout landing on the same cycle.
                if (relock_req) begin
                    restart = 1'b1;
                end else if (lock_s_q && stable_cnt_q == STAB_LAST) begin
                    state_d = S_RELEASE;
                end else if (timeout_cnt_q == TOUT_LAST) begin
                    state_d       = S_RESET;
                    pll_rst_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    if (retry_count_q != 4'd15) begin
                        retry_count_d = retry_count_q + 4'd1;
                    end
                end
            end

            S_RELEASE: begin
                if (!lock_s_q || relock_req) begin
                    restart     = 1'b1;
                    lock_lost_d = ~lock_s_q;
                end else if (domain_reset_q == '0) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end else if (gap_cnt_q == GAP_LAST) begin
                    // Shifting in zeros from the bottom releases index 0 first.
                    domain_reset_d = domain_reset_q << 1;
                    gap_cnt_d      = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                if (!lock_s_q || relock_req) begin
                    restart     = 1'b1;
                    lock_lost_d = ~lock_s_q;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase

        if (restart) begin
            state_d        = S_RESET;
            pll_rst_d      = 1'b1;
            domain_reset_d = '1;
            ready_d        = 1'b0;
        end

        if (state_d != state_q) begin
            hold_cnt_d    = '0;
            stable_cnt_d  = '0;
            timeout_cnt_d = '0;
            gap_cnt_d     = '0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q        <= S_RESET;
            hold_cnt_q     <= '0;
            stable_cnt_q   <= '0;
            timeout_cnt_q  <= '0;
            gap_cnt_q      <= '0;
            pll_rst_q      <= 1'b1;
            domain_reset_q <= '1;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
            retry_count_q  <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            stable_cnt_q   <= stable_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            pll_rst_q      <= pll_rst_d;
            domain_reset_q <= domain_reset_d;
            ready_q        <= ready_d;
            lock_lost_q    <= lock_lost_d;
            retry_count_q  <= retry_count_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_reset = domain_reset_q;
    assign ready        = ready_q;
    assign lock_lost    = lock_lost_q;
    assign retry_count  = retry_count_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; expected waveforms are hand-derived
// edge numbers counted from the first rising edge after rst falls.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic [2:0] domain_reset;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .RELEASE_GAP        (2),
        .NUM_DOMAINS        (3)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .domain_reset(domain_reset),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .retry_count (retry_count),
        .timeout_err (timeout_err)
    );

    task automatic apply_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        n_cmp++; if (domain_reset !== 3'b111) begin n_err++; $display("FAIL reset_domain got %b want 111", domain_reset); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
        n_cmp++; if (retry_count !== 4'd0) begin n_err++; $display("FAIL reset_retry got %0d want 0", retry_count); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    endtask

    // pll_locked sampled high from edge 6: lock_s at 7, release at 15, 000 at 21, ready at 22.
    task automatic test_bringup();
        logic       exp_rst, exp_rdy;
        logic [2:0] exp_dom;
        apply_reset();
        for (int k = 1; k <= 24; k++) begin
            @(posedge refclk); #1;
            exp_rst = (k < 4);
            exp_dom = (k < 17) ? 3'b111 : (k < 19) ? 3'b110 : (k < 21) ? 3'b100 : 3'b000;
            exp_rdy = (k >= 22);
            n_cmp++; if (pll_rst !== exp_rst) begin n_err++; $display("FAIL bringup_pll_rst k=%0d got %b want %b", k, pll_rst, exp_rst); end
            n_cmp++; if (domain_reset !== exp_dom) begin n_err++; $display("FAIL bringup_domain k=%0d got %b want %b", k, domain_reset, exp_dom); end
            n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL bringup_ready k=%0d got %b want %b", k, ready, exp_rdy); end
            n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL bringup_lock_lost k=%0d got %b want 0", k, lock_lost); end
            if (k == 5) pll_locked = 1'b1;
        end
        n_cmp++; if (retry_count !== 4'd0) begin n_err++; $display("FAIL bringup_retry got %0d want 0", retry_count); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL bringup_timeout_err got %b want 0", timeout_err); end
    endtask

    // Each failed attempt is 4 reset + 32 wait edges; timeouts land on multiples of 36.
    task automatic test_timeout();
        logic       exp_rst, exp_rdy, exp_terr;
        logic [3:0] exp_retry;
        logic [2:0] exp_dom;
        apply_reset();
        for (int k = 1; k <= 632; k++) begin
            @(posedge refclk); #1;
            exp_rst   = (k <= 612) ? ((k % 36) < 4) : (k < 616);
            exp_retry = (k / 36 > 15) ? 4'd15 : 4'(k / 36);
            exp_terr  = (k >= 36);
            exp_dom   = (k < 626) ? 3'b111 : (k < 628) ? 3'b110 : (k < 630) ? 3'b100 : 3'b000;
            exp_rdy   = (k >= 631);
            n_cmp++; if (pll_rst !== exp_rst) begin n_err++; $display("FAIL timeout_pll_rst k=%0d got %b want %b", k, pll_rst, exp_rst); end
            n_cmp++; if (retry_count !== exp_retry) begin n_err++; $display("FAIL timeout_retry k=%0d got %0d want %0d", k, retry_count, exp_retry); end
            n_cmp++; if (timeout_err !== exp_terr) begin n_err++; $display("FAIL timeout_err k=%0d got %b want %b", k, timeout_err, exp_terr); end
            n_cmp++; if (domain_reset !== exp_dom) begin n_err++; $display("FAIL timeout_domain k=%0d got %b want %b", k, domain_reset, exp_dom); end
            n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL timeout_ready k=%0d got %b want %b", k, ready, exp_rdy); end
            if (k == 612) pll_locked = 1'b1;
        end
    endtask

    // Lock high for samples 5..11, low at 12, high again: release at 22 instead of 14.
    task automatic test_lock_glitch();
        logic       exp_rst, exp_rdy;
        logic [2:0] exp_dom;
        apply_reset();
        for (int k = 1; k <= 30; k++) begin
            @(posedge refclk); #1;
            exp_rst = (k < 4);
            exp_dom = (k < 24) ? 3'b111 : (k < 26) ? 3'b110 : (k < 28) ? 3'b100 : 3'b000;
            exp_rdy = (k >= 29);
            n_cmp++; if (pll_rst !== exp_rst) begin n_err++; $display("FAIL glitch_pll_rst k=%0d got %b want %b", k, pll_rst, exp_rst); end
            n_cmp++; if (domain_reset !== exp_dom) begin n_err++; $display("FAIL glitch_domain k=%0d got %b want %b", k, domain_reset, exp_dom); end
            n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL glitch_ready k=%0d got %b want %b", k, ready, exp_rdy); end
            if (k == 4)  pll_locked = 1'b1;
            if (k == 11) pll_locked = 1'b0;
            if (k == 12) pll_locked = 1'b1;
        end
    endtask

    // Starts in S_RUN. One low sample at edge 1 reaches the outputs at edge 3.
    task automatic test_loss_in_run();
        logic       exp_rst, exp_rdy, exp_ll;
        logic [2:0] exp_dom;
        pll_locked = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge refclk); #1;
            exp_ll  = (k == 3);
            exp_rst = (k >= 3) && (k < 7);
            exp_dom = (k < 3) ? 3'b000 : (k < 17) ? 3'b111 : (k < 19) ? 3'b110 : (k < 21) ? 3'b100 : 3'b000;
            exp_rdy = (k < 3) || (k >= 22);
            n_cmp++; if (lock_lost !== exp_ll) begin n_err++; $display("FAIL loss_lock_lost k=%0d got %b want %b", k, lock_lost, exp_ll); end
            n_cmp++; if (pll_rst !== exp_rst) begin n_err++; $display("FAIL loss_pll_rst k=%0d got %b want %b", k, pll_rst, exp_rst); end
            n_cmp++; if (domain_reset !== exp_dom) begin n_err++; $display("FAIL loss_domain k=%0d got %b want %b", k, domain_reset, exp_dom); end
            n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL loss_ready k=%0d got %b want %b", k, ready, exp_rdy); end
            if (k == 1) pll_locked = 1'b1;
        end
    endtask

    // Relock from S_RUN at edge 1, then again during release (domain_reset=100) at edge 18.
    task automatic test_relock();
        logic       exp_rst, exp_rdy;
        logic [2:0] exp_dom;
        relock_req = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            @(posedge refclk); #1;
            exp_rst = (k < 5) || ((k >= 18) && (k < 22));
            exp_dom = (k < 15) ? 3'b111 : (k < 17) ? 3'b110 : (k < 18) ? 3'b100 :
                      (k < 32) ? 3'b111 : (k < 34) ? 3'b110 : (k < 36) ? 3'b100 : 3'b000;
            exp_rdy = (k >= 37);
            n_cmp++; if (pll_rst !== exp_rst) begin n_err++; $display("FAIL relock_pll_rst k=%0d got %b want %b", k, pll_rst, exp_rst); end
            n_cmp++; if (domain_reset !== exp_dom) begin n_err++; $display("FAIL relock_domain k=%0d got %b want %b", k, domain_reset, exp_dom); end
            n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL relock_ready k=%0d got %b want %b", k, ready, exp_rdy); end
            n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL relock_lock_lost k=%0d got %b want 0", k, lock_lost); end
            if (k == 1)  relock_req = 1'b0;
            if (k == 17) relock_req = 1'b1;
            if (k == 18) relock_req = 1'b0;
        end
    endtask

    // Second lock wait (edges 41..72) with one timeout recorded, then rst mid-cycle.
    task automatic test_async_reset();
        apply_reset();
        repeat (45) @(posedge refclk);
        #1;
        n_cmp++; if (pll_rst !== 1'b0) begin n_err++; $display("FAIL async_pre_pll_rst got %b want 0", pll_rst); end
        n_cmp++; if (retry_count !== 4'd1) begin n_err++; $display("FAIL async_pre_retry got %0d want 1", retry_count); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL async_pre_timeout_err got %b want 1", timeout_err); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL async_pll_rst got %b want 1", pll_rst); end
        n_cmp++; if (domain_reset !== 3'b111) begin n_err++; $display("FAIL async_domain got %b want 111", domain_reset); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL async_ready got %b want 0", ready); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL async_lock_lost got %b want 0", lock_lost); end
        n_cmp++; if (retry_count !== 4'd0) begin n_err++; $display("FAIL async_retry got %0d want 0", retry_count); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL async_timeout_err got %b want 0", timeout_err); end
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_lock_glitch();
        test_loss_in_run();
        test_relock();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
